// File: rtl/ddr_bank_scheduler.sv
// Purpose: single-port DDR command scheduler with open-page bank tracking and periodic refresh.
// Latency: row hit -> column command 1 cycle after accept; closed bank -> ACT +1, RD/WR +1+T_RCD.
// Backpressure: req_ready is low from accept until the FSM is back in IDLE, and while refresh is pending.
module ddr_bank_scheduler #(
  parameter int BGWIDTH  = 2,
  parameter int BAWIDTH  = 2,
  parameter int ROWWIDTH = 16,
  parameter int COLWIDTH = 10,
  parameter int BL       = 8,
  parameter int T_RCD    = 17,
  parameter int T_RP     = 17,
  parameter int T_WR     = 14,
  parameter int T_RTP    = 7,
  parameter int T_RFC    = 34,
  parameter int T_REFI   = 10400,
  localparam int AW      = (ROWWIDTH > COLWIDTH) ? ROWWIDTH : COLWIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [BGWIDTH-1:0]  req_bg,
  input  logic [BAWIDTH-1:0]  req_ba,
  input  logic [ROWWIDTH-1:0] req_row,
  input  logic [COLWIDTH-1:0] req_col,
  output logic [18:0]         commands,
  output logic [BGWIDTH-1:0]  bg,
  output logic [BAWIDTH-1:0]  ba,
  output logic [AW-1:0]       addr,
  output logic                ref_busy
);

  localparam int IW     = BGWIDTH + BAWIDTH;
  localparam int NB     = 1 << IW;
  localparam int TMAX_A = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int TMAX_B = ((BL + T_WR) > T_RTP) ? (BL + T_WR) : T_RTP;
  localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int CW     = $clog2(((T_RFC > T_RP) ? T_RFC : T_RP) + 1);
  localparam int RW     = $clog2(T_REFI);

  // One-hot positions on the command bus
  localparam int B_ACT = 18;
  localparam int B_PR  = 7;
  localparam int B_PRA = 6;
  localparam int B_RD  = 5;
  localparam int B_REF = 3;
  localparam int B_WR  = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_ACT, S_COL, S_RPRA, S_RWAIT_RP, S_RREF, S_RWAIT_RFC
  } state_t;

  state_t                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  ref_busy_q, ref_busy_d;
  logic                  ref_pending_q, ref_pending_d;
  logic [RW-1:0]         ref_cnt_q, ref_cnt_d;
  logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
  logic [18:0]           cmd_q, cmd_d;
  logic [BGWIDTH-1:0]    bg_q, bg_d;
  logic [BAWIDTH-1:0]    ba_q, ba_d;
  logic [AW-1:0]         addr_q, addr_d;

  // Latched request
  logic                  lat_write_q, lat_write_d;
  logic [BGWIDTH-1:0]    lat_bg_q, lat_bg_d;
  logic [BAWIDTH-1:0]    lat_ba_q, lat_ba_d;
  logic [ROWWIDTH-1:0]   lat_row_q, lat_row_d;
  logic [COLWIDTH-1:0]   lat_col_q, lat_col_d;

  // Per-bank state: t_ac gates ACT (after PR) and RD/WR (after ACT); t_pr gates PR/PRA
  logic                  open_q [NB];
  logic                  open_d [NB];
  logic [ROWWIDTH-1:0]   row_q  [NB];
  logic [ROWWIDTH-1:0]   row_d  [NB];
  logic [TW-1:0]         t_ac_q [NB];
  logic [TW-1:0]         t_ac_d [NB];
  logic [TW-1:0]         t_pr_q [NB];
  logic [TW-1:0]         t_pr_d [NB];

  logic [IW-1:0]         cur_idx, in_idx;
  logic                  accept, ref_pulse, any_open, pra_ok;
  logic [TW-1:0]         rec_t;

  assign commands  = cmd_q;
  assign bg        = bg_q;
  assign ba        = ba_q;
  assign addr      = addr_q;
  assign req_ready = req_ready_q;
  assign ref_busy  = ref_busy_q;

  // Next-state logic: timers, refresh bookkeeping, FSM transitions and command selection
  always_comb begin
    state_d       = state_q;
    req_ready_d   = 1'b0;
    ref_cnt_d     = ref_cnt_q + RW'(1);
    wait_cnt_d    = wait_cnt_q;
    cmd_d         = '0;
    bg_d          = '0;
    ba_d          = '0;
    addr_d        = '0;
    lat_write_d   = lat_write_q;
    lat_bg_d      = lat_bg_q;
    lat_ba_d      = lat_ba_q;
    lat_row_d     = lat_row_q;
    lat_col_d     = lat_col_q;
    open_d        = open_q;
    row_d         = row_q;
    rec_t         = '0;
    cur_idx       = {lat_bg_q, lat_ba_q};
    in_idx        = {req_bg, req_ba};
    accept        = (state_q == S_IDLE) && req_ready_q && req_valid;
    any_open      = 1'b0;
    pra_ok        = 1'b1;

    for (int i = 0; i < NB; i++) begin
      t_ac_d[i] = (t_ac_q[i] != '0) ? t_ac_q[i] - TW'(1) : '0;
      t_pr_d[i] = (t_pr_q[i] != '0) ? t_pr_q[i] - TW'(1) : '0;
      if (open_q[i]) begin
        any_open = 1'b1;
        if (t_pr_q[i] > TW'(1)) pra_ok = 1'b0;
      end
    end

    // A pulse arriving while refresh is already pending is simply lost
    ref_pulse = (ref_cnt_q == RW'(T_REFI - 1));
    if (ref_pulse) ref_cnt_d = '0;
    ref_pending_d = ref_pending_q | ref_pulse;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          lat_write_d = req_write;
          lat_bg_d    = req_bg;
          lat_ba_d    = req_ba;
          lat_row_d   = req_row;
          lat_col_d   = req_col;
          if (open_q[in_idx] && (row_q[in_idx] == req_row)) state_d = S_COL;
          else if (!open_q[in_idx])                         state_d = S_ACT;
          else                                              state_d = S_PRE;
        end else if (ref_pending_q) begin
          state_d = any_open ? S_RPRA : S_RREF;
        end else begin
          req_ready_d = !ref_pending_d;
        end
      end
      S_PRE: begin
        if (t_pr_q[cur_idx] <= TW'(1)) begin
          cmd_d[B_PR]     = 1'b1;
          bg_d            = lat_bg_q;
          ba_d            = lat_ba_q;
          open_d[cur_idx] = 1'b0;
          t_ac_d[cur_idx] = TW'(T_RP);
          state_d         = S_ACT;
        end
      end
      S_ACT: begin
        if (t_ac_q[cur_idx] <= TW'(1)) begin
          cmd_d[B_ACT]    = 1'b1;
          bg_d            = lat_bg_q;
          ba_d            = lat_ba_q;
          addr_d          = AW'(lat_row_q);
          open_d[cur_idx] = 1'b1;
          row_d[cur_idx]  = lat_row_q;
          t_ac_d[cur_idx] = TW'(T_RCD);
          state_d         = S_COL;
        end
      end
      S_COL: begin
        if (t_ac_q[cur_idx] <= TW'(1)) begin
          cmd_d[B_WR] = lat_write_q;
          cmd_d[B_RD] = !lat_write_q;
          bg_d        = lat_bg_q;
          ba_d        = lat_ba_q;
          addr_d      = AW'(lat_col_q);
          // Keep the longest outstanding PR restriction for this bank
          rec_t       = lat_write_q ? TW'(BL + T_WR) : TW'(T_RTP);
          if (rec_t > t_pr_d[cur_idx]) t_pr_d[cur_idx] = rec_t;
          state_d     = S_IDLE;
        end
      end
      S_RPRA: begin
        if (pra_ok) begin
          cmd_d[B_PRA] = 1'b1;
          for (int i = 0; i < NB; i++) begin
            open_d[i] = 1'b0;
            t_ac_d[i] = TW'(T_RP);
          end
          wait_cnt_d = CW'(T_RP - 1);
          state_d    = S_RWAIT_RP;
        end
      end
      S_RWAIT_RP: begin
        // Counter is primed so that REF lands exactly T_RP after PRA
        if (wait_cnt_q <= CW'(1)) state_d = S_RREF;
        else                      wait_cnt_d = wait_cnt_q - CW'(1);
      end
      S_RREF: begin
        cmd_d[B_REF] = 1'b1;
        wait_cnt_d   = CW'(T_RFC);
        state_d      = S_RWAIT_RFC;
      end
      S_RWAIT_RFC: begin
        if (wait_cnt_q <= CW'(1)) begin
          ref_pending_d = 1'b0;
          req_ready_d   = 1'b1;
          state_d       = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    ref_busy_d = ref_pending_d;
  end

  // State and registered outputs; reset abandons any in-flight operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b0;
      ref_busy_q    <= 1'b0;
      ref_pending_q <= 1'b0;
      ref_cnt_q     <= '0;
      wait_cnt_q    <= '0;
      cmd_q         <= '0;
      bg_q          <= '0;
      ba_q          <= '0;
      addr_q        <= '0;
      lat_write_q   <= 1'b0;
      lat_bg_q      <= '0;
      lat_ba_q      <= '0;
      lat_row_q     <= '0;
      lat_col_q     <= '0;
      for (int i = 0; i < NB; i++) begin
        open_q[i] <= 1'b0;
        row_q[i]  <= '0;
        t_ac_q[i] <= '0;
        t_pr_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      ref_busy_q    <= ref_busy_d;
      ref_pending_q <= ref_pending_d;
      ref_cnt_q     <= ref_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      cmd_q         <= cmd_d;
      bg_q          <= bg_d;
      ba_q          <= ba_d;
      addr_q        <= addr_d;
      lat_write_q   <= lat_write_d;
      lat_bg_q      <= lat_bg_d;
      lat_ba_q      <= lat_ba_d;
      lat_row_q     <= lat_row_d;
      lat_col_q     <= lat_col_d;
      for (int i = 0; i < NB; i++) begin
        open_q[i] <= open_d[i];
        row_q[i]  <= row_d[i];
        t_ac_q[i] <= t_ac_d[i];
        t_pr_q[i] <= t_pr_d[i];
      end
    end
  end

endmodule

// File: doc/ddr_bank_scheduler.md
Name: ddr_bank_scheduler

Overview:
- Single-port command scheduler in front of the per-bank TimingFSM.
- Accepts read/write requests with bank-group/bank/row/column, tracks open rows per bank, and issues ACT/PR/PRA/RD/WR/REF respecting tRCD, tRP, tWR, tRTP and tRFC.
- Runs periodic refresh at tREFI.
- Drives the 19-bit one-hot commands bus plus bg/ba exactly as TimingFSM consumes them.

Parameters:
BGWIDTH, 2, bank-group address width
BAWIDTH, 2, bank address width per group
ROWWIDTH, 16, row address width
COLWIDTH, 10, column address width
BL, 8, burst length in cycles
T_RCD, 17, ACT to RD/WR same bank
T_RP, 17, PR/PRA to ACT/REF
T_WR, 14, write recovery after burst end
T_RTP, 7, RD to PR same bank
T_RFC, 34, REF to any command
T_REFI, 10400, refresh interval in cycles

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&ready
req_write  in  1  1=write, 0=read
req_bg  in  BGWIDTH  bank group
req_ba  in  BAWIDTH  bank
req_row  in  ROWWIDTH  row
req_col  in  COLWIDTH  column
commands  out  19  one-hot {ACT,BST,CFG,CKEH,CKEL,DPD,DPDX,MRR,MRW,PD,PDX,PR,PRA,RD,RDA,REF,SRF,WR,WRA}; ACT=bit18, PR=7, PRA=6, RD=5, REF=3, WR=1; all other bits tied 0
bg  out  BGWIDTH  target bank group of current command
ba  out  BAWIDTH  target bank of current command
addr  out  max(ROWWIDTH,COLWIDTH)  row for ACT, column (zero-extended) for RD/WR, 0 otherwise
ref_busy  out  1  high from refresh-pending until tRFC expiry

Behaviour:
- Clock/reset: one clock, clk. Synchronous active-high reset. During reset: commands=0, bg=0, ba=0, addr=0, req_ready=0, ref_busy=0, all open flags cleared, all bank timers 0, refresh counter 0, FSM=IDLE. req_ready=1 on the first cycle after reset deasserts.
- Commands: at most one command bit high per cycle. Outputs are registered and are zero on cycles with no command.
- Per-bank state: open flag, open row, timer. Same-bank spacing from a command at cycle c:
  - ACT→RD/WR: ≥ c+T_RCD
  - PR→ACT: ≥ c+T_RP
  - WR→PR: ≥ c+BL+T_WR
  - RD→PR: ≥ c+T_RTP
  - A command issues on the first cycle its constraint allows. No extra bubbles.
- FSM states: IDLE, PRE, ACT, COL, RPRA, RWAIT_RP, RREF, RWAIT_RFC.
- IDLE:
  - req_ready = !ref_pending. Accept latches the request.
  - Next state: COL on open-row hit, ACT if the bank is closed, PRE if a different row is open.
  - If ref_pending and no request was accepted: go to RPRA if any bank is open, else RREF.
- PRE: issue PR when the bank timer allows; clear open flag; → ACT.
- ACT: issue ACT when tRP is satisfied; set open flag and row; → COL.
- COL: issue RD or WR when tRCD is satisfied; → IDLE. Open-page policy: the row stays open.
- Request latency (accept at cycle N):
  - Hit with idle timer: RD/WR at N+1.
  - Closed bank: ACT at N+1, RD/WR at N+1+T_RCD.
  - Row miss: PR at N+1 (or later if the timer blocks), ACT at PR+T_RP, RD/WR at ACT+T_RCD.
  - req_ready is low from accept until return to IDLE.
- Refresh:
  - Free-running counter pulses ref_pending every T_REFI cycles from reset.
  - A pulse while already pending is dropped (no postponement credit).
  - An in-flight request always completes its column command before refresh starts.
  - RPRA: issue PRA once every open bank meets its PR constraint; clear all open flags.
  - RWAIT_RP: wait T_RP.
  - RREF: issue REF with bg=0, ba=0, addr=0.
  - RWAIT_RFC: wait T_RFC; clear ref_pending; → IDLE.
  - ref_busy is high from the pending pulse through the last RWAIT_RFC cycle.
- Simultaneous events: a request valid in the same cycle that refresh becomes pending is accepted (pending is visible to req_ready from the next cycle).
- Reset mid-sequence: abandons the operation immediately. No command is issued in the reset cycle.

Test Plan:
- Reset 3 cycles, then req write bg0 ba1 row 0x12 col 0x40 → ACT(bit18) bg0 ba1 addr 0x12 at N+1; WR(bit1) addr 0x40 at N+18; req_ready high at N+19.
- Same bank, read of row 0x12 issued right after the write → RD at acceptance+1 (hit); a following PR to that bank is never earlier than WR+22.
- Row miss: bank1 open on 0x12, request row 0x34 → PR ≥ WR+22, ACT exactly PR+17, RD exactly ACT+17.
- Two banks (ba1, ba2) opened, bench T_REFI=300 → after the current column cmd: PRA, REF 17 cycles later, req_ready low and ref_busy high until REF+34; all banks treated closed afterward (next request issues ACT).
- Request valid in the exact cycle ref_pending rises → request accepted and completes; refresh follows; no second REF for that interval.
- Assert reset 5 cycles after ACT → commands stay 0, no RD/WR issued; after release, the same request issues ACT again (bank seen closed).
